// File: rtl/load_store_unit.sv
// Data-memory initiator: accepts one load/store at a time, drives the big-endian
// byte-addressed memory and returns exactly one response per request.
module load_store_unit #(
   parameter int MEM_BYTES = 3000,
   parameter int MEM_LAT   = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_err,
   output logic        mem_we,
   output logic [2:0]  mem_wmode,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic [3:0]  LAT       = 4'(MEM_LAT);
   localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

   state_t      state;
   logic [3:0]  wait_cnt;
   logic        store_reg;
   logic [1:0]  size_reg;
   logic        signed_reg;

   logic [2:0]  req_mode;
   logic [1:0]  bytes_minus1;
   logic [32:0] last_byte;
   logic        req_bad;
   logic [31:0] load_ext;

   always_comb begin
      req_mode = 3'b010;
      case (req_size)
         2'b00:   req_mode = req_signed ? 3'b000 : 3'b011;
         2'b01:   req_mode = req_signed ? 3'b001 : 3'b100;
         default: req_mode = 3'b010;
      endcase
   end

   // 33-bit sum so that an access wrapping past 0xFFFFFFFF lands above the limit
   assign bytes_minus1 = {req_size[1], req_size[1] | req_size[0]};
   assign last_byte    = {1'b0, req_addr} + {31'd0, bytes_minus1};
   assign req_bad      = (req_size == 2'b11)
                       | ((req_size == 2'b01) & req_addr[0])
                       | ((req_size == 2'b10) & (req_addr[1:0] != 2'b00))
                       | (last_byte >= MEM_LIMIT);

   always_comb begin
      load_ext = mem_rdata;
      case (size_reg)
         2'b00:   load_ext = {{24{signed_reg & mem_rdata[7]}},  mem_rdata[7:0]};
         2'b01:   load_ext = {{16{signed_reg & mem_rdata[15]}}, mem_rdata[15:0]};
         default: load_ext = mem_rdata;
      endcase
   end

   assign req_ready = (state == IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= 4'd0;
         store_reg  <= 1'b0;
         size_reg   <= 2'b00;
         signed_reg <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= 32'd0;
         rsp_err    <= 1'b0;
         mem_we     <= 1'b0;
         mem_wmode  <= 3'b000;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  mem_addr   <= req_addr;
                  mem_wdata  <= req_wdata;
                  mem_wmode  <= req_mode;
                  store_reg  <= req_we;
                  size_reg   <= req_size;
                  signed_reg <= req_signed;
                  if (req_bad) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= 32'd0;
                  end else begin
                     state    <= ISSUE;
                     wait_cnt <= LAT;
                     // write strobe is registered, so it is raised on entry to the final ISSUE cycle
                     mem_we   <= req_we && (LAT == 4'd0);
                  end
               end
            end
            ISSUE: begin
               if (wait_cnt == 4'd0) begin
                  mem_we    <= 1'b0;
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= store_reg ? 32'd0 : load_ext;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
                  mem_we   <= store_reg && (wait_cnt == 4'd1);
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, latency/reset corner sequences and
// random traffic checked against a byte-array reference memory.
module tb_load_store_unit;
   localparam int MEM_BYTES = 3000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        req_we = 1'b0, req_signed = 1'b0, rsp_ready = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic [31:0] req_addr = 32'd0, req_wdata = 32'd0, lat_rdata = 32'd0;
   logic        v0 = 1'b0, v2 = 1'b0, v3 = 1'b0;

   logic        rdy0, rv0, err0, we0;
   logic [31:0] rd0, ma0, mwd0, mrd0;
   logic [2:0]  mm0;
   logic        rdy2, rv2, err2, we2;
   logic [31:0] rd2, ma2, mwd2;
   logic [2:0]  mm2;
   logic        rdy3, rv3, err3, we3;
   logic [31:0] rd3, ma3, mwd3;
   logic [2:0]  mm3;

   load_store_unit #(.MEM_BYTES(MEM_BYTES), .MEM_LAT(0)) u0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv0), .rsp_ready(rsp_ready), .rsp_data(rd0), .rsp_err(err0),
      .mem_we(we0), .mem_wmode(mm0), .mem_addr(ma0), .mem_wdata(mwd0), .mem_rdata(mrd0));

   load_store_unit #(.MEM_BYTES(MEM_BYTES), .MEM_LAT(2)) u2 (
      .clk(clk), .rst(rst), .req_valid(v2), .req_ready(rdy2), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv2), .rsp_ready(rsp_ready), .rsp_data(rd2), .rsp_err(err2),
      .mem_we(we2), .mem_wmode(mm2), .mem_addr(ma2), .mem_wdata(mwd2), .mem_rdata(lat_rdata));

   load_store_unit #(.MEM_BYTES(MEM_BYTES), .MEM_LAT(3)) u3 (
      .clk(clk), .rst(rst), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
      .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rv3), .rsp_ready(rsp_ready), .rsp_data(rd3), .rsp_err(err3),
      .mem_we(we3), .mem_wmode(mm3), .mem_addr(ma3), .mem_wdata(mwd3), .mem_rdata(lat_rdata));

   // big-endian memory behind u0; junk in the unused upper bits of narrow reads
   logic [7:0]  dmem [0:MEM_BYTES-1];
   logic [31:0] a0, a1, a2, a3;
   assign a0 = ma0 % 32'(MEM_BYTES);
   assign a1 = (ma0 + 32'd1) % 32'(MEM_BYTES);
   assign a2 = (ma0 + 32'd2) % 32'(MEM_BYTES);
   assign a3 = (ma0 + 32'd3) % 32'(MEM_BYTES);

   always_comb begin
      case (mm0)
         3'b000, 3'b011: mrd0 = {24'h5A5A5A, dmem[a0]};
         3'b001, 3'b100: mrd0 = {16'hA5A5, dmem[a0], dmem[a1]};
         default:        mrd0 = {dmem[a0], dmem[a1], dmem[a2], dmem[a3]};
      endcase
   end

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_BYTES; i++) dmem[i] <= 8'h00;
      end else if (we0) begin
         case (mm0)
            3'b000, 3'b011: dmem[a0] <= mwd0[7:0];
            3'b001, 3'b100: begin
               dmem[a0] <= mwd0[15:8];
               dmem[a1] <= mwd0[7:0];
            end
            default: begin
               dmem[a0] <= mwd0[31:24];
               dmem[a1] <= mwd0[23:16];
               dmem[a2] <= mwd0[15:8];
               dmem[a3] <= mwd0[7:0];
            end
         endcase
      end
   end

   int we0_cnt = 0, we2_cnt = 0, we3_cnt = 0;
   always @(posedge clk) begin
      we0_cnt <= we0_cnt + (we0 ? 1 : 0);
      we2_cnt <= we2_cnt + (we2 ? 1 : 0);
      we3_cnt <= we3_cnt + (we3 ? 1 : 0);
   end

   int checks = 0, errors = 0, txn_no = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // reference model: a plain byte array and the access rules
   logic [7:0] ref_mem [0:MEM_BYTES-1];

   function automatic logic [2:0] mode_of(input logic [1:0] size, input logic sgn);
      if (size == 2'd0) return sgn ? 3'b000 : 3'b011;
      if (size == 2'd1) return sgn ? 3'b001 : 3'b100;
      return 3'b010;
   endfunction

   task automatic ref_txn(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] d, output logic e);
      int n;
      logic [63:0] last, v;
      n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      last = {32'd0, addr} + 64'(n - 1);
      e    = (size == 2'd3) || ((addr % 32'(n)) != 32'd0) || (last >= 64'(MEM_BYTES));
      d    = 32'd0;
      if (!e) begin
         if (we) begin
            for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = wdata[8*(n-1-i) +: 8];
         end else begin
            v = 64'd0;
            for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[addr + 32'(i)]);
            if (sgn && n < 4 && v[8*n-1]) v = v - (64'd1 << (8*n));
            d = v[31:0];
         end
      end
   endtask

   task automatic run_txn(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_d, input logic exp_e,
                          input logic [2:0] exp_mode, input int hold);
      int guard, lat, base;
      logic [2:0] mode_seen;
      @(negedge clk);
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      v0 = 1'b1;
      guard = 0;
      while (!rdy0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("req_ready", 32'(rdy0), 32'd1);
      base = we0_cnt;
      @(posedge clk);
      #1 v0 = 1'b0;
      lat = 0;
      mode_seen = 3'b111;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat == 1) mode_seen = mm0;
         if (rv0) break;
      end
      check("rsp_latency", 32'(lat), exp_e ? 32'd1 : 32'd2);
      check("rsp_valid", 32'(rv0), 32'd1);
      check("rsp_data", rd0, exp_d);
      check("rsp_err", 32'(err0), 32'(exp_e));
      if (!exp_e) check("mem_wmode", 32'(mode_seen), 32'(exp_mode));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_valid", 32'(rv0 & ~rdy0), 32'd1);
         check("hold_data", rd0, exp_d);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;
      check("ready_after_rsp", 32'({rdy0, rv0}), 32'd2);
      check("mem_we_pulses", 32'(we0_cnt - base), (we && !exp_e) ? 32'd1 : 32'd0);
      $display("txn %0d: we=%0d size=%0d sgn=%0d addr=%h wdata=%h -> data=%h err=%0d lat=%0d",
               txn_no, we, size, sgn, addr, wdata, rd0, err0, lat);
      txn_no++;
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_d;
      logic        exp_e;
      logic [2:0]  exp_mode;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] exp_d, input logic exp_e, input logic [2:0] exp_mode);
      vec_t r;
      r.we = we; r.size = size; r.sgn = sgn; r.addr = addr; r.wdata = wdata;
      r.exp_d = exp_d; r.exp_e = exp_e; r.exp_mode = exp_mode;
      return r;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl [$];
      int   n, base;
      logic [31:0] dummy_d;
      logic        dummy_e;

      for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;

      tbl.push_back(mk(1, 2'd2, 0, 32'h10,       32'hDEADBEEF, 32'h0,        0, 3'b010));
      tbl.push_back(mk(0, 2'd2, 0, 32'h10,       32'h0,        32'hDEADBEEF, 0, 3'b010));
      tbl.push_back(mk(0, 2'd0, 1, 32'h10,       32'h0,        32'hFFFFFFDE, 0, 3'b000));
      tbl.push_back(mk(0, 2'd0, 0, 32'h10,       32'h0,        32'h000000DE, 0, 3'b011));
      tbl.push_back(mk(0, 2'd1, 0, 32'h11,       32'h0,        32'h0,        1, 3'b100));
      tbl.push_back(mk(0, 2'd2, 0, 32'h12,       32'h0,        32'h0,        1, 3'b010));
      tbl.push_back(mk(0, 2'd3, 0, 32'h10,       32'h0,        32'h0,        1, 3'b010));
      tbl.push_back(mk(1, 2'd2, 0, 32'd2996,     32'h01234567, 32'h0,        0, 3'b010));
      tbl.push_back(mk(0, 2'd2, 0, 32'd2996,     32'h0,        32'h01234567, 0, 3'b010));
      tbl.push_back(mk(0, 2'd2, 0, 32'd2997,     32'h0,        32'h0,        1, 3'b010));
      tbl.push_back(mk(0, 2'd0, 0, 32'hFFFFFFFF, 32'h0,        32'h0,        1, 3'b011));
      tbl.push_back(mk(1, 2'd1, 1, 32'h20,       32'hFFFF8001, 32'h0,        0, 3'b001));
      tbl.push_back(mk(0, 2'd1, 0, 32'h20,       32'h0,        32'h00008001, 0, 3'b100));
      tbl.push_back(mk(0, 2'd1, 1, 32'h20,       32'h0,        32'hFFFF8001, 0, 3'b001));
      tbl.push_back(mk(0, 2'd0, 0, 32'h11,       32'h0,        32'h000000AD, 0, 3'b011));
      tbl.push_back(mk(1, 2'd0, 0, 32'h13,       32'h12345677, 32'h0,        0, 3'b011));
      tbl.push_back(mk(0, 2'd2, 1, 32'h10,       32'h0,        32'hDEADBE77, 0, 3'b010));
      tbl.push_back(mk(1, 2'd1, 0, 32'h21,       32'hAAAA5555, 32'h0,        1, 3'b100));
      tbl.push_back(mk(0, 2'd1, 0, 32'd2998,     32'h0,        32'h00004567, 0, 3'b100));
      tbl.push_back(mk(0, 2'd0, 0, 32'd2999,     32'h0,        32'h00000067, 0, 3'b011));
      tbl.push_back(mk(0, 2'd0, 0, 32'd3000,     32'h0,        32'h0,        1, 3'b011));

      // reset values are asserted asynchronously, before any clock edge
      #1 rst = 1'b1;
      #2;
      check("reset_rsp_valid", 32'(rv0), 32'd0);
      check("reset_rsp_data", rd0, 32'd0);
      check("reset_rsp_err", 32'(err0), 32'd0);
      check("reset_mem_we", 32'(we0), 32'd0);
      check("reset_mem_wmode", 32'(mm0), 32'd0);
      check("reset_mem_addr", ma0, 32'd0);
      check("reset_mem_wdata", mwd0, 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_ready_all", 32'({rdy0, rdy2, rdy3}), 32'd7);

      // reset in the middle of a MEM_LAT=3 store
      @(negedge clk);
      req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
      v3 = 1'b1;
      base = we3_cnt;
      @(posedge clk);
      #1 v3 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("t1_rst_rsp_valid", 32'(rv3), 32'd0);
      check("t1_rst_mem_we", 32'(we3), 32'd0);
      check("t1_rst_mem_addr", ma3, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (6) begin
         @(negedge clk);
         check("t1_no_rsp", 32'(rv3), 32'd0);
      end
      check("t1_no_we_pulse", 32'(we3_cnt - base), 32'd0);
      check("t1_ready", 32'(rdy3), 32'd1);

      // undisturbed MEM_LAT=3 store: four ISSUE cycles, one strobe
      @(negedge clk);
      req_we = 1'b1; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h34; req_wdata = 32'h600DF00D;
      v3 = 1'b1;
      base = we3_cnt;
      @(posedge clk);
      #1 v3 = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         n++;
         if (rv3) break;
      end
      check("t1b_latency", 32'(n), 32'd5);
      check("t1b_we_pulses", 32'(we3_cnt - base), 32'd1);
      check("t1b_rsp", {rd3[30:0], err3}, 32'd0);
      check("t1b_mem_addr", ma3, 32'h34);
      check("t1b_mem_wdata", mwd3, 32'h600DF00D);
      check("t1b_mem_wmode", 32'(mm3), 32'd2);
      rsp_ready = 1'b1;
      @(posedge clk);
      #1 rsp_ready = 1'b0;

      // MEM_LAT=2 load with a stalled response
      lat_rdata = 32'h13579BDF;
      @(negedge clk);
      req_we = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h40; req_wdata = 32'h55AA55AA;
      v2 = 1'b1;
      check("t6_ready", 32'(rdy2), 32'd1);
      base = we2_cnt;
      @(posedge clk);
      #1 v2 = 1'b0;
      n = 0;
      while (n < 20) begin
         @(negedge clk);
         if (rv2) break;
         check("t6_busy", 32'(rdy2), 32'd0);
         n++;
      end
      check("t6_issue_cycles", 32'(n), 32'd3);
      lat_rdata = 32'h0BADF00D;
      check("t6_data", rd2, 32'h13579BDF);
      check("t6_err", 32'(err2), 32'd0);
      check("t6_mem_side", {ma2[29:0], mm2[1:0]}, {30'h40, 2'b10});
      check("t6_mem_wdata", mwd2, 32'h55AA55AA);
      repeat (5) begin
         @(negedge clk);
         check("t6_hold_valid", 32'({rv2, rdy2}), 32'd2);
         check("t6_hold_data", rd2, 32'h13579BDF);
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      check("t6_ready_during_rsp", 32'({rv2, rdy2}), 32'd2);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("t6_ready_after_rsp", 32'({rv2, rdy2}), 32'd1);
      check("t6_no_we", 32'(we2_cnt - base), 32'd0);

      // directed vectors
      for (int i = 0; i < tbl.size(); i++) begin
         ref_txn(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, dummy_d, dummy_e);
         run_txn(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata,
                 tbl[i].exp_d, tbl[i].exp_e, tbl[i].exp_mode, i % 3);
      end

      // random traffic against the reference memory
      for (int t = 0; t < 200; t++) begin
         logic        r_we, r_sgn, r_e;
         logic [1:0]  r_size;
         logic [31:0] r_addr, r_wdata, r_d;
         int          pick, s;
         pick    = int'($urandom_range(0, 9));
         if (pick < 6)      r_addr = 32'($urandom_range(0, 63));
         else if (pick < 8) r_addr = 32'($urandom_range(2988, 3003));
         else               r_addr = $urandom();
         s       = int'($urandom_range(0, 7));
         r_size  = (s == 7) ? 2'd3 : 2'(s % 3);
         r_we    = 1'($urandom_range(0, 1));
         r_sgn   = 1'($urandom_range(0, 1));
         r_wdata = $urandom();
         ref_txn(r_we, r_size, r_sgn, r_addr, r_wdata, r_d, r_e);
         run_txn(r_we, r_size, r_sgn, r_addr, r_wdata, r_d, r_e, mode_of(r_size, r_sgn),
                 int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
